// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WS_W = 4;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic for sub-word accesses: byte enables, store replication, load extract/extend.
// Only present when DMEM_SUBWORD_EN is defined.
`ifdef DMEM_SUBWORD_EN
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rshift = rword >> {addr_lo, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rword;
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

endmodule
`endif

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states; one outstanding request at a time.
// Sub-word (byte/half) accesses are enabled by defining DMEM_SUBWORD_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WS_W-1:0] WS_LOAD = (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

    state_t          state_q, state_d;
    logic [WS_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]      size_q, size_d;
    logic            go_resp;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the array is accessed on the accept edge, before the
    // request registers are loaded, so the live request is used while in IDLE.
    logic        cur_we, cur_uns;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;

    assign cur_we    = (state_q == IDLE) ? req_we       : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr     : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
    assign cur_size  = (state_q == IDLE) ? req_size     : size_q;
    assign cur_uns   = (state_q == IDLE) ? req_unsigned : uns_q;

    logic [AW-1:0] idx;
    logic          oob, misalign, acc_err, mem_we;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep, rword, rdata_ext;

    assign idx   = cur_addr[AW+1:2];
    assign oob   = |cur_addr[31:AW+2];
    assign rword = mem[idx];

`ifdef DMEM_SUBWORD_EN
    always_comb begin
        misalign = 1'b0;
        case (cur_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = cur_addr[0];
            SZ_WORD: misalign = |cur_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    dmem_lane u_lane (
        .addr_lo     (cur_addr[1:0]),
        .size        (cur_size),
        .is_unsigned (cur_uns),
        .wdata       (cur_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );
`else
    logic unused_cfg;
    assign misalign   = |cur_addr[1:0];
    assign byte_en    = 4'b1111;
    assign wdata_rep  = cur_wdata;
    assign rdata_ext  = rword;
    assign unused_cfg = ^{cur_size, cur_uns};
`endif

    assign acc_err = oob | misalign;
    assign mem_we  = go_resp & cur_we & ~acc_err & ~reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (go_resp) begin
            err_d   = acc_err;
            rdata_d = (cur_we || acc_err) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 3 and 2 wait states.
// Sub-word vectors run when DMEM_SUBWORD_EN is defined, word-only vectors otherwise.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [1:0]  req_size [3];
    logic        req_unsigned [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err [3];

    int n_tests = 0;
    int n_fail  = 0;
    int ws_of [3] = '{0, 3, 2};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One handshake on instance d; checks data, error, latency, ready-low span and strobe width.
    task automatic acc(input string tag, input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int guard;
        int lat;
        int rdy_low;
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_valid[d]    = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        rdy_low = 0;
        while (!rsp_valid[d] && lat < 40) begin
            if (!req_ready[d]) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
        if (!req_ready[d]) rdy_low++;
        check({tag, " rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        check({tag, " latency"}, 32'(lat), 32'(ws_of[d]));
        check({tag, " ready low"}, 32'(rdy_low), 32'(ws_of[d] + 1));
        @(posedge clk); #1;
        check({tag, " strobe width"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        int seen;
        for (int d = 0; d < 3; d++) begin
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_addr[d]     = '0;
            req_wdata[d]    = '0;
            req_size[d]     = SZ_WORD;
            req_unsigned[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset ready", 32'(req_ready[d]), 32'd0);
            check("reset valid", 32'(rsp_valid[d]), 32'd0);
            check("reset rdata", rsp_rdata[d], 32'h0);
            check("reset err", 32'(rsp_err[d]), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("ready after init", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;

        // zero wait states
        acc("ws0 st 10", 0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 32'h0, 1'b0);
        acc("ws0 ld 10", 0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);

        // three wait states, plus hold of response data after the strobe
        acc("ws3 st 40", 1, 1'b1, 32'h40, 32'h0BADF00D, SZ_WORD, 1'b0, 32'h0, 1'b0);
        acc("ws3 ld 40", 1, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, 32'h0BADF00D, 1'b0);
        @(posedge clk); #1;
        check("ws3 rdata hold", rsp_rdata[1], 32'h0BADF00D);

        // range boundaries
        acc("st 0", 0, 1'b1, 32'h0, 32'hA5A5A5A5, SZ_WORD, 1'b0, 32'h0, 1'b0);
        acc("st 3fc", 0, 1'b1, 32'h3FC, 32'h5A5A5A5A, SZ_WORD, 1'b0, 32'h0, 1'b0);
        acc("ld 3fc", 0, 1'b0, 32'h3FC, 32'h0, SZ_WORD, 1'b0, 32'h5A5A5A5A, 1'b0);
        acc("ld 400 oob", 0, 1'b0, 32'h400, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b1);
        acc("st 400 oob", 0, 1'b1, 32'h400, 32'h12345678, SZ_WORD, 1'b0, 32'h0, 1'b1);
        acc("ld fffffffc oob", 0, 1'b0, 32'hFFFFFFFC, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b1);
        acc("ld 0 after oob", 0, 1'b0, 32'h0, 32'h0, SZ_WORD, 1'b0, 32'hA5A5A5A5, 1'b0);
        acc("ld 3fc after oob", 0, 1'b0, 32'h3FC, 32'h0, SZ_WORD, 1'b0, 32'h5A5A5A5A, 1'b0);

        // misaligned word accesses
        acc("ld 12 misalign", 0, 1'b0, 32'h12, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b1);
        acc("st 12 misalign", 0, 1'b1, 32'h12, 32'hFFFFFFFF, SZ_WORD, 1'b0, 32'h0, 1'b1);
        acc("ld 10 intact", 0, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_SUBWORD_EN
        acc("ld half 13", 0, 1'b0, 32'h13, 32'h0, SZ_HALF, 1'b0, 32'h0, 1'b1);
        acc("ld size 11", 0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        acc("st w 20", 0, 1'b1, 32'h20, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b0);
        acc("st b 21", 0, 1'b1, 32'h21, 32'h12345680, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        acc("ld w 20 a", 0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 32'h00008000, 1'b0);
        acc("ld sb 21", 0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0, 32'hFFFFFF80, 1'b0);
        acc("ld ub 21", 0, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 32'h00000080, 1'b0);
        acc("st h 22", 0, 1'b1, 32'h22, 32'hABCDBEEF, SZ_HALF, 1'b0, 32'h0, 1'b0);
        acc("st b 20", 0, 1'b1, 32'h20, 32'h0000007F, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        acc("ld w 20 b", 0, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 32'hBEEF807F, 1'b0);
        acc("ld sh 22", 0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b0, 32'hFFFFBEEF, 1'b0);
        acc("ld uh 22", 0, 1'b0, 32'h22, 32'h0, SZ_HALF, 1'b1, 32'h0000BEEF, 1'b0);
        acc("ld sh 20", 0, 1'b0, 32'h20, 32'h0, SZ_HALF, 1'b0, 32'hFFFF807F, 1'b0);
        acc("ld ub 23", 0, 1'b0, 32'h23, 32'h0, SZ_BYTE, 1'b1, 32'h000000BE, 1'b0);
        acc("ld sb 20", 0, 1'b0, 32'h20, 32'h0, SZ_BYTE, 1'b0, 32'h0000007F, 1'b0);
`else
        acc("ld 10 size ignored", 0, 1'b0, 32'h10, 32'h0, SZ_BYTE, 1'b1, 32'hDEADBEEF, 1'b0);
        acc("ld 11 byte err", 0, 1'b0, 32'h11, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b1);
        acc("st 10 half as word", 0, 1'b1, 32'h10, 32'h01020304, SZ_HALF, 1'b0, 32'h0, 1'b0);
        acc("ld 10 full word", 0, 1'b0, 32'h10, 32'h0, SZ_BYTE, 1'b0, 32'h01020304, 1'b0);
`endif

        // reset pulsed while a store is waiting
        acc("ws2 st 30", 2, 1'b1, 32'h30, 32'h11111111, SZ_WORD, 1'b0, 32'h0, 1'b0);
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'h22222222;
        req_size[2]  = SZ_WORD;
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        check("ws2 in wait", 32'(req_ready[2]), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("wait reset valid", 32'(rsp_valid[2]), 32'd0);
        check("wait reset ready", 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready after release", 32'(req_ready[2]), 32'd1);
        seen = 0;
        repeat (6) begin
            if (rsp_valid[2]) seen++;
            @(posedge clk); #1;
        end
        check("no rsp after reset", 32'(seen), 32'd0);
        acc("ws2 ld 30 old", 2, 1'b0, 32'h30, 32'h0, SZ_WORD, 1'b0, 32'h11111111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
